reg_bank_param: RTL

Parametrised successor to the 32x32 register bank. It has configurable data width, depth and read-port count, and synchronous reset clearing of all entries. It adds an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending (busy) scoreboard for hazard detection. It sits in the datapath between decode (read addresses, pending marks) and writeback (write port).

---
 rtl/reg_bank_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/reg_bank_param.sv
// reg_bank_param: parametrised register bank for the decode/writeback datapath.
// Provides NUM_RD registered read ports, one write port, an optional hardwired
// zero entry, optional write-to-read forwarding and a per-entry pending
// scoreboard used for hazard detection.
module reg_bank_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regwrite,
  input  logic [ADDR_W-1:0]        wreg,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic              wr_en;
  logic              pend_en;

  // Entry 0 silently drops writes and pending marks when it is hardwired to zero.
  assign wr_en   = regwrite && !((ZERO_REG != 0) && (wreg == '0));
  assign pend_en = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

  // Storage array: cleared on reset, otherwise updated by the writeback port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wreg] <= WriteData;
    end
  end

  // Next pending vector: a write retires its entry, a new mark sets one; set wins on a tie.
  always_comb begin
    pending_next = pending;
    if (wr_en) begin
      pending_next[wreg] = 1'b0;
    end
    if (pend_en) begin
      pending_next[pend_addr] = 1'b1;
    end
  end

  // Scoreboard register and its registered summary flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      any_busy <= 1'b0;
    end else begin
      pending  <= pending_next;
      any_busy <= |pending_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = (BYPASS != 0) && regwrite && (wreg == addr);

    // Registered read: zero entry first, then same-cycle forwarding, then stored state.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (is_zero) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (hit) begin
        data_q <= WriteData;
        busy_q <= 1'b0;
      end else begin
        data_q <= mem[addr];
        busy_q <= pending[addr];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_q;
    assign rd_busy[k]                  = busy_q;
  end

endmodule
